// File: rtl/e_tile_dispatch_if.sv
// e_tile_dispatch_if: result input, operand-network and write-queue ports of e_tile_dispatch.
interface e_tile_dispatch_if #(
  parameter int NUM_TARGETS = 2,
  parameter int DATA_W = 64,
  parameter int INSTR_W = 7
);
  logic res_valid;
  logic res_ready;
  logic [DATA_W-1:0] res_data;
  logic [NUM_TARGETS-1:0] res_tgt_valid;
  logic [NUM_TARGETS*INSTR_W-1:0] res_tgt_instr;
  logic [NUM_TARGETS*2-1:0] res_tgt_slot;
  logic [NUM_TARGETS-1:0] res_tgt_wq;
  logic net_req;
  logic net_ack;
  logic [DATA_W-1:0] net_data;
  logic [INSTR_W-1:0] net_dest_instr;
  logic [1:0] net_dest_slot;
  logic [7:0] net_src;
  logic wq_req;
  logic wq_ack;
  logic [4:0] wq_queue_id;
  logic [DATA_W-1:0] wq_data;
  modport master (
    input  res_valid, res_data, res_tgt_valid, res_tgt_instr, res_tgt_slot, res_tgt_wq, net_ack, wq_ack,
    output res_ready, net_req, net_data, net_dest_instr, net_dest_slot, net_src, wq_req, wq_queue_id, wq_data
  );
  modport slave (
    output res_valid, res_data, res_tgt_valid, res_tgt_instr, res_tgt_slot, res_tgt_wq, net_ack, wq_ack,
    input  res_ready, net_req, net_data, net_dest_instr, net_dest_slot, net_src, wq_req, wq_queue_id, wq_data
  );
endinterface

// File: rtl/e_tile_dispatch.sv
// e_tile_dispatch: result FIFO fanning each result out to its targets, one handshake per target.
// ETILE_DISPATCH_WQ_EN: write-queue targets use wq_*; otherwise they go on the network with slot 3.
module e_tile_dispatch #(
  parameter int NUM_TARGETS = 2,
  parameter int DEPTH = 4,
  parameter int DATA_W = 64,
  parameter int INSTR_W = 7,
  parameter logic [7:0] NODE_ID = 8'd0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  e_tile_dispatch_if.master bus,
  output logic busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1;
`ifdef ETILE_DISPATCH_WQ_EN
  localparam bit WQ_EN = 1'b1;
`else
  localparam bit WQ_EN = 1'b0;
`endif
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] data_m [DEPTH];
  logic [NUM_TARGETS*INSTR_W-1:0] instr_m [DEPTH];
  logic [NUM_TARGETS*2-1:0] slot_m [DEPTH];
  logic [NUM_TARGETS-1:0] wq_m [DEPTH];
  logic [NUM_TARGETS-1:0] pend_m [DEPTH];
  logic [AW-1:0] rd_q, wr_q, hd_ptr;
  logic [AW:0] count_q, count_d;
  logic [TW-1:0] tgt_q, tgt_d;
  logic push, fire, pop, fresh, go, t_wq;
  logic [NUM_TARGETS-1:0] done, pend_now, hd_pend, hd_wq;
  logic [DATA_W-1:0] hd_data;
  logic [NUM_TARGETS*INSTR_W-1:0] hd_instr;
  logic [NUM_TARGETS*2-1:0] hd_slot;
  logic [INSTR_W-1:0] t_instr;
  logic [1:0] t_slot;
  logic busy_q, net_req_q, net_req_d, wq_req_q, wq_req_d;
  logic [DATA_W-1:0] net_data_q, net_data_d, wq_data_q, wq_data_d;
  logic [INSTR_W-1:0] net_instr_q, net_instr_d;
  logic [1:0] net_slot_q, net_slot_d;
  logic [7:0] net_src_q;
  logic [4:0] wq_id_q, wq_id_d;
  // Outputs are registered, so the head seen after this edge (popped or freshly pushed) is selected here.
  always_comb begin
    done = '0;
    done[tgt_q] = 1'b1;
    fire = state_q == SEND && !flush && (net_req_q && bus.net_ack || wq_req_q && bus.wq_ack);
    pend_now = fire ? pend_m[rd_q] & ~done : pend_m[rd_q];
    pop = fire && pend_now == '0;
    push = bus.res_valid && bus.res_ready && bus.res_tgt_valid != '0 && !flush;
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    fresh = push && (count_q == '0 || pop && count_q == (AW+1)'(1));
    hd_ptr = pop ? rd_q + 1'b1 : rd_q;
    hd_pend = fresh ? bus.res_tgt_valid : pop ? pend_m[hd_ptr] : pend_now;
    hd_data = fresh ? bus.res_data : data_m[hd_ptr];
    hd_instr = fresh ? bus.res_tgt_instr : instr_m[hd_ptr];
    hd_slot = fresh ? bus.res_tgt_slot : slot_m[hd_ptr];
    hd_wq = fresh ? bus.res_tgt_wq : wq_m[hd_ptr];
    tgt_d = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--)
      if (hd_pend[i]) tgt_d = TW'(i);
    t_instr = hd_instr[tgt_d*INSTR_W +: INSTR_W];
    t_slot = hd_slot[tgt_d*2 +: 2];
    t_wq = hd_wq[tgt_d];
    state_d = count_d != '0 ? SEND : IDLE;
    go = state_d == SEND;
    wq_req_d = WQ_EN && go && t_wq;
    net_req_d = go && !wq_req_d;
    net_data_d = net_req_d ? hd_data : '0;
    net_instr_d = net_req_d ? t_instr : '0;
    net_slot_d = !net_req_d ? 2'd0 : t_wq ? 2'd3 : t_slot;
    wq_data_d = wq_req_d ? hd_data : '0;
    wq_id_d = wq_req_d ? t_instr[4:0] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      tgt_q <= '0;
      busy_q <= 1'b0;
      net_req_q <= 1'b0;
      wq_req_q <= 1'b0;
      net_data_q <= '0;
      net_instr_q <= '0;
      net_slot_q <= '0;
      net_src_q <= '0;
      wq_data_q <= '0;
      wq_id_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= flush ? '0 : hd_ptr;
      wr_q <= flush ? '0 : push ? wr_q + 1'b1 : wr_q;
      count_q <= count_d;
      tgt_q <= tgt_d;
      busy_q <= count_d != '0;
      net_req_q <= net_req_d;
      wq_req_q <= wq_req_d;
      net_data_q <= net_data_d;
      net_instr_q <= net_instr_d;
      net_slot_q <= net_slot_d;
      net_src_q <= net_req_d ? NODE_ID : 8'd0;
      wq_data_q <= wq_data_d;
      wq_id_q <= wq_id_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_m[wr_q] <= bus.res_data;
      instr_m[wr_q] <= bus.res_tgt_instr;
      slot_m[wr_q] <= bus.res_tgt_slot;
      wq_m[wr_q] <= bus.res_tgt_wq;
      pend_m[wr_q] <= bus.res_tgt_valid;
    end
    if (fire && !pop) pend_m[rd_q] <= pend_now;
  end
  assign bus.res_ready = count_q != (AW+1)'(DEPTH);
  assign bus.net_req = net_req_q;
  assign bus.net_data = net_data_q;
  assign bus.net_dest_instr = net_instr_q;
  assign bus.net_dest_slot = net_slot_q;
  assign bus.net_src = net_src_q;
  assign bus.wq_req = wq_req_q;
  assign bus.wq_queue_id = wq_id_q;
  assign bus.wq_data = wq_data_q;
  assign busy = busy_q;
  assign count = count_q;
endmodule

// File: tb/tb_e_tile_dispatch.sv
// tb_e_tile_dispatch: directed and randomized stimulus against a target-queue scoreboard.
module tb_e_tile_dispatch;
  localparam int NT = 2;
  localparam int DEPTH = 4;
  localparam logic [7:0] NODE = 8'h2A;
`ifdef ETILE_DISPATCH_WQ_EN
  localparam bit WQ_EN = 1'b1;
`else
  localparam bit WQ_EN = 1'b0;
`endif
  typedef struct {
    logic port_wq;
    logic [6:0] instr;
    logic [1:0] slot;
    logic [63:0] data;
    bit last;
  } rec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic busy;
  logic [2:0] count;
  int checks = 0;
  int fails = 0;
  int mcount = 0;
  bit mready;
  rec_t q[$];
  e_tile_dispatch_if #(.NUM_TARGETS(NT), .DATA_W(64), .INSTR_W(7)) bus();
  e_tile_dispatch #(.NUM_TARGETS(NT), .DEPTH(DEPTH), .DATA_W(64), .INSTR_W(7), .NODE_ID(NODE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .busy(busy), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  // Expected targets in service order: index order within a result, result order across the FIFO.
  task automatic enqueue();
    int last_i = -1;
    for (int i = 0; i < NT; i++)
      if (bus.res_tgt_valid[i]) last_i = i;
    for (int i = 0; i < NT; i++)
      if (bus.res_tgt_valid[i]) begin
        rec_t r;
        r.port_wq = WQ_EN && bus.res_tgt_wq[i];
        r.instr = bus.res_tgt_instr[i*7 +: 7];
        r.slot = (bus.res_tgt_wq[i] && !WQ_EN) ? 2'd3 : bus.res_tgt_slot[i*2 +: 2];
        r.data = bus.res_data;
        r.last = i == last_i;
        q.push_back(r);
      end
    mcount++;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcount = 0;
    end else begin
      chk("res_ready", 64'(bus.res_ready), 64'(mcount != DEPTH));
      chk("count", 64'(count), 64'(mcount));
      chk("busy", 64'(busy), 64'(mcount != 0));
      if (q.size() == 0) begin
        chk("net_req idle", 64'(bus.net_req), 64'(0));
        chk("wq_req idle", 64'(bus.wq_req), 64'(0));
      end else if (q[0].port_wq) begin
        chk("wq_req", 64'(bus.wq_req), 64'(1));
        chk("net_req off", 64'(bus.net_req), 64'(0));
        chk("wq_queue_id", 64'(bus.wq_queue_id), 64'(q[0].instr[4:0]));
        chk("wq_data", bus.wq_data, q[0].data);
      end else begin
        chk("net_req", 64'(bus.net_req), 64'(1));
        chk("wq_req off", 64'(bus.wq_req), 64'(0));
        chk("net_data", bus.net_data, q[0].data);
        chk("net_dest_instr", 64'(bus.net_dest_instr), 64'(q[0].instr));
        chk("net_dest_slot", 64'(bus.net_dest_slot), 64'(q[0].slot));
        chk("net_src", 64'(bus.net_src), 64'(NODE));
      end
      mready = mcount != DEPTH;
      if (flush) begin
        q.delete();
        mcount = 0;
      end else begin
        if (q.size() != 0 && (q[0].port_wq ? bus.wq_ack : bus.net_ack)) begin
          if (q[0].last) mcount--;
          void'(q.pop_front());
        end
        if (bus.res_valid && mready && bus.res_tgt_valid != '0) enqueue();
      end
    end
  end
  task automatic set_res(input logic [63:0] d, input logic [1:0] tv, input logic [13:0] ins,
                         input logic [3:0] sl, input logic [1:0] wq);
    bus.res_data = d;
    bus.res_tgt_valid = tv;
    bus.res_tgt_instr = ins;
    bus.res_tgt_slot = sl;
    bus.res_tgt_wq = wq;
  endtask
  task automatic push(input logic [63:0] d, input logic [1:0] tv, input logic [13:0] ins,
                      input logic [3:0] sl, input logic [1:0] wq);
    set_res(d, tv, ins, sl, wq);
    bus.res_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.res_ready) begin
        @(posedge clk);
        #1 bus.res_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    fails++;
    $display("FAIL push timeout: res_ready stayed 0, expected 1 within 100 cycles");
    bus.res_valid = 1'b0;
  endtask
  task automatic drain();
    for (int k = 0; k < 300 && mcount != 0; k++) @(posedge clk);
    if (mcount != 0) begin
      checks++;
      fails++;
      $display("FAIL drain timeout: %0d entries left, expected 0", mcount);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.res_valid = 1'b0;
    set_res('0, '0, '0, '0, '0);
    bus.net_ack = 1'b0;
    bus.wq_ack = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset net_req", 64'(bus.net_req), 64'(0));
    chk("reset wq_req", 64'(bus.wq_req), 64'(0));
    chk("reset count", 64'(count), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset res_ready", 64'(bus.res_ready), 64'(1));
    chk("reset net_data", bus.net_data, 64'(0));
    chk("reset net_src", 64'(bus.net_src), 64'(0));
    chk("reset wq_queue_id", 64'(bus.wq_queue_id), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.net_ack = 1'b1;
    bus.wq_ack = 1'b1;
    push(64'h1234, 2'b11, {7'd9, 7'd5}, {2'd1, 2'd0}, 2'b00);
    drain();
    bus.wq_ack = 1'b0;
    push(64'hABCD, 2'b11, {7'd17, 7'h23}, {2'd2, 2'd0}, 2'b01);
    repeat (2) @(posedge clk);
    #1 bus.wq_ack = 1'b1;
    drain();
    push(64'h77, 2'b01, {7'd0, 7'd7}, 4'd0, 2'b01);
    drain();
    bus.net_ack = 1'b0;
    bus.wq_ack = 1'b0;
    for (int i = 0; i < 4; i++)
      push(64'h100 + 64'(i), 2'b11, {7'(20 + i), 7'(10 + i)}, {2'd2, 2'd1}, 2'b00);
    @(negedge clk);
    chk("full count", 64'(count), 64'(4));
    chk("full res_ready", 64'(bus.res_ready), 64'(0));
    fork
      begin
        repeat (4) @(posedge clk);
        #1 bus.net_ack = 1'b1;
      end
    join_none
    push(64'h104, 2'b11, {7'd24, 7'd14}, {2'd0, 2'd1}, 2'b00);
    drain();
    bus.net_ack = 1'b0;
    for (int i = 0; i < 3; i++)
      push(64'h200 + 64'(i), 2'b11, {7'(40 + i), 7'(30 + i)}, {2'd1, 2'd2}, 2'b00);
    set_res(64'hDEAD, 2'b11, {7'd3, 7'd2}, 4'd0, 2'b00);
    bus.res_valid = 1'b1;
    bus.net_ack = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.res_valid = 1'b0;
    bus.net_ack = 1'b0;
    @(negedge clk);
    chk("flush count", 64'(count), 64'(0));
    chk("flush net_req", 64'(bus.net_req), 64'(0));
    @(posedge clk);
    #1 push(64'h55, 2'b11, {7'd8, 7'd6}, 4'd0, 2'b00);
    push(64'h66, 2'b00, {7'd1, 7'd1}, 4'd0, 2'b00);
    @(negedge clk);
    chk("zero-mask count", 64'(count), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset net_req", 64'(bus.net_req), 64'(0));
    chk("async reset count", 64'(count), 64'(0));
    chk("async reset res_ready", 64'(bus.res_ready), 64'(1));
    chk("async reset busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      bus.res_valid = $urandom_range(0, 2) != 0;
      bus.res_data = {$urandom, $urandom};
      bus.res_tgt_valid = 2'($urandom_range(0, 3));
      bus.res_tgt_instr = 14'($urandom);
      bus.res_tgt_slot = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      bus.res_tgt_wq = 2'($urandom);
      bus.net_ack = $urandom_range(0, 3) != 0;
      bus.wq_ack = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 49) == 0;
      @(posedge clk);
      #1;
    end
    bus.res_valid = 1'b0;
    flush = 1'b0;
    bus.net_ack = 1'b1;
    bus.wq_ack = 1'b1;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
